cr_bmu_ibus_initiator: RTL and testbench

Initiator side of the BMU-to-TCIPIF instruction bus. Accepts one upstream fetch/access request at a time, drives the ibus request/address/write/deny fields until granted, then waits for completion and returns a registered one-cycle response upstream. Denied accesses are completed locally with an error, and accesses that never complete are terminated by a timeout. It sits in the BMU in front of any TCIPIF ibus responder, including the dummy error-only responder.

---
 rtl/cr_bmu_ibus_initiator.sv | 180 ++++++++++++++++++
 tb/tb_cr_bmu_ibus_initiator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_bmu_ibus_initiator.sv
// cr_bmu_ibus_initiator
// Initiator side of the BMU-to-TCIPIF instruction bus. Accepts one upstream
// request at a time, presents it on the ibus until granted, waits for the
// responder's completion and returns a registered one-cycle response.
// Denied accesses complete locally with an error. A WAIT that never completes
// is closed with a timeout error, and the late completion is later flushed.

module cr_bmu_ibus_initiator #(
  parameter int unsigned TIMEOUT_CYC = 255,  // legal range 1 .. 2**CNT_W-1
  parameter int unsigned CNT_W       = 8
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst,
  // upstream (IFU) request
  input  logic        ifu_bmu_req,
  input  logic [31:0] ifu_bmu_addr,
  input  logic        ifu_bmu_write,
  input  logic        ifu_bmu_acc_deny,
  // upstream (IFU) grant and response
  output logic        bmu_ifu_grnt,
  output logic        bmu_ifu_trans_cmplt,
  output logic        bmu_ifu_acc_err,
  output logic        bmu_ifu_data_vld,
  output logic [31:0] bmu_ifu_data,
  // ibus request
  output logic        bmu_tcipif_ibus_req,
  output logic [31:0] bmu_tcipif_ibus_addr,
  output logic        bmu_tcipif_ibus_write,
  output logic        bmu_tcipif_ibus_acc_deny,
  // ibus response
  input  logic        tcipif_bmu_ibus_grnt,
  input  logic        tcipif_bmu_ibus_trans_cmplt,
  input  logic        tcipif_bmu_ibus_acc_err,
  input  logic        tcipif_bmu_ibus_data_vld,
  input  logic [31:0] tcipif_bmu_ibus_data
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DENY  = 3'd3;
  localparam logic [2:0] ST_FLUSH = 3'd4;

  // Counter value in the last WAIT cycle before giving up.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic             write_q, write_d;
  logic             deny_q, deny_d;
  logic             rsp_cmplt_q, rsp_cmplt_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rsp_dvld_q, rsp_dvld_d;
  logic [31:0]      rsp_data_q, rsp_data_d;

  // Read data is only meaningful when the responder flags it and no error.
  logic             bus_dvld;
  assign bus_dvld = tcipif_bmu_ibus_data_vld & ~tcipif_bmu_ibus_acc_err;

  // Handshake outputs are decoded from state; they are also held low while
  // reset is asserted so nothing leaks out in the reset cycle itself.
  assign bmu_ifu_grnt        = (state_q == ST_IDLE) & ifu_bmu_req & ~cpurst;
  assign bmu_tcipif_ibus_req = (state_q == ST_REQ) & ~cpurst;

  assign bmu_tcipif_ibus_addr     = addr_q;
  assign bmu_tcipif_ibus_write    = write_q;
  assign bmu_tcipif_ibus_acc_deny = deny_q;

  assign bmu_ifu_trans_cmplt = rsp_cmplt_q;
  assign bmu_ifu_acc_err     = rsp_err_q;
  assign bmu_ifu_data_vld    = rsp_dvld_q;
  assign bmu_ifu_data        = rsp_data_q;

  // Next-state, request latch and response formation.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    deny_d      = deny_q;
    // Response registers pulse for exactly one cycle, so they default to 0.
    rsp_cmplt_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_dvld_d  = 1'b0;
    rsp_data_d  = '0;

    case (state_q)
      ST_IDLE: begin
        // Completions arriving here belong to nobody and are ignored.
        if (ifu_bmu_req) begin
          addr_d  = ifu_bmu_addr;
          write_d = ifu_bmu_write;
          deny_d  = ifu_bmu_acc_deny;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // Wait indefinitely for the grant; a stray completion is ignored.
        if (tcipif_bmu_ibus_grnt) begin
          if (deny_q) begin
            state_d = ST_DENY;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // Completion is checked first so it wins over a same-cycle timeout.
        if (tcipif_bmu_ibus_trans_cmplt) begin
          rsp_cmplt_d = 1'b1;
          rsp_err_d   = tcipif_bmu_ibus_acc_err;
          rsp_dvld_d  = bus_dvld;
          rsp_data_d  = bus_dvld ? tcipif_bmu_ibus_data : 32'd0;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          rsp_cmplt_d = 1'b1;
          rsp_err_d   = 1'b1;
          state_d     = ST_FLUSH;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DENY: begin
        // The responder never completes a denied access; answer locally.
        rsp_cmplt_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = ST_IDLE;
      end

      ST_FLUSH: begin
        // Swallow the late completion of the timed-out access silently.
        if (tcipif_bmu_ibus_trans_cmplt) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, latched request fields and response registers.
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      // NOTE: the latched address and response data are reset too, because
      // these registers drive outputs that must read 0 out of reset.
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      deny_q      <= 1'b0;
      rsp_cmplt_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dvld_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      deny_q      <= deny_d;
      rsp_cmplt_q <= rsp_cmplt_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dvld_q  <= rsp_dvld_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_cr_bmu_ibus_initiator.sv
// tb_cr_bmu_ibus_initiator
// Table-driven transactions with a response scoreboard, plus hand-written
// sequences for timeout/flush and mid-transaction reset.

module tb_cr_bmu_ibus_initiator;

  localparam int unsigned TO_CYC = 4;

  logic        clk;
  logic        cpurst;
  logic        ifu_bmu_req;
  logic [31:0] ifu_bmu_addr;
  logic        ifu_bmu_write;
  logic        ifu_bmu_acc_deny;
  logic        bmu_ifu_grnt;
  logic        bmu_ifu_trans_cmplt;
  logic        bmu_ifu_acc_err;
  logic        bmu_ifu_data_vld;
  logic [31:0] bmu_ifu_data;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_write;
  logic        bus_deny;
  logic        tc_grnt;
  logic        tc_cmplt;
  logic        tc_err;
  logic        tc_dvld;
  logic [31:0] tc_data;

  cr_bmu_ibus_initiator #(
    .TIMEOUT_CYC(TO_CYC),
    .CNT_W      (8)
  ) dut (
    .forever_cpuclk             (clk),
    .cpurst                     (cpurst),
    .ifu_bmu_req                (ifu_bmu_req),
    .ifu_bmu_addr               (ifu_bmu_addr),
    .ifu_bmu_write              (ifu_bmu_write),
    .ifu_bmu_acc_deny           (ifu_bmu_acc_deny),
    .bmu_ifu_grnt               (bmu_ifu_grnt),
    .bmu_ifu_trans_cmplt        (bmu_ifu_trans_cmplt),
    .bmu_ifu_acc_err            (bmu_ifu_acc_err),
    .bmu_ifu_data_vld           (bmu_ifu_data_vld),
    .bmu_ifu_data               (bmu_ifu_data),
    .bmu_tcipif_ibus_req        (bus_req),
    .bmu_tcipif_ibus_addr       (bus_addr),
    .bmu_tcipif_ibus_write      (bus_write),
    .bmu_tcipif_ibus_acc_deny   (bus_deny),
    .tcipif_bmu_ibus_grnt       (tc_grnt),
    .tcipif_bmu_ibus_trans_cmplt(tc_cmplt),
    .tcipif_bmu_ibus_acc_err    (tc_err),
    .tcipif_bmu_ibus_data_vld   (tc_dvld),
    .tcipif_bmu_ibus_data       (tc_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: at the falling edge of cycle n, cyc == n.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One stimulus record: request, responder behaviour, expected response.
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic        deny;
    int          gnt_dly;
    int          cmp_dly;
    logic        r_err;
    logic        r_dvld;
    logic [31:0] r_data;
    logic        exp_err;
    logic        exp_dvld;
    logic [31:0] exp_data;
    int          exp_lat;   // accept cycle to response cycle
  } vec_t;

  typedef struct {
    logic        err;
    logic        dvld;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];

  // Response monitor: every upstream pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (bmu_ifu_trans_cmplt === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_rsp", bmu_ifu_trans_cmplt, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_w("rsp_cycle", cyc, e.due);
        check("rsp_err", bmu_ifu_acc_err, e.err);
        check("rsp_dvld", bmu_ifu_data_vld, e.dvld);
        check_w("rsp_data", bmu_ifu_data, e.data);
      end
    end
  end

  task automatic idle_inputs();
    ifu_bmu_req      = 1'b0;
    ifu_bmu_addr     = '0;
    ifu_bmu_write    = 1'b0;
    ifu_bmu_acc_deny = 1'b0;
    tc_grnt          = 1'b0;
    tc_cmplt         = 1'b0;
    tc_err           = 1'b0;
    tc_dvld          = 1'b0;
    tc_data          = '0;
  endtask

  // Runs one transaction; entered just after a rising edge with the DUT able
  // to accept, returns just after the rising edge that starts the response
  // cycle, so the next call checks same-cycle re-acceptance.
  task automatic do_txn(input vec_t v);
    int a;
    idle_inputs();
    ifu_bmu_req      = 1'b1;
    ifu_bmu_addr     = v.addr;
    ifu_bmu_write    = v.write;
    ifu_bmu_acc_deny = v.deny;
    @(negedge clk);
    check("accept_grnt", bmu_ifu_grnt, 1'b1);
    a = cyc;
    sb.push_back('{v.exp_err, v.exp_dvld, v.exp_data, a + v.exp_lat});
    @(posedge clk); #1;
    for (int g = 0; g <= v.gnt_dly; g++) begin
      // Keep a different request pending while busy: it must not be granted
      // nor disturb the latched bus fields.
      ifu_bmu_req      = (g < v.gnt_dly);
      ifu_bmu_addr     = ~v.addr;
      ifu_bmu_write    = ~v.write;
      ifu_bmu_acc_deny = ~v.deny;
      tc_grnt          = (g == v.gnt_dly);
      @(negedge clk);
      check("bus_req", bus_req, 1'b1);
      check_w("bus_addr", bus_addr, v.addr);
      check("bus_write", bus_write, v.write);
      check("bus_deny", bus_deny, v.deny);
      if (g < v.gnt_dly) check("busy_no_grnt", bmu_ifu_grnt, 1'b0);
      @(posedge clk); #1;
    end
    idle_inputs();
    if (v.deny) begin
      @(negedge clk);
      check("deny_req_low", bus_req, 1'b0);
      @(posedge clk); #1;
    end else begin
      for (int w = 0; w < v.cmp_dly; w++) begin
        @(negedge clk);
        check("wait_req_low", bus_req, 1'b0);
        @(posedge clk); #1;
      end
      tc_cmplt = 1'b1;
      tc_err   = v.r_err;
      tc_dvld  = v.r_dvld;
      tc_data  = v.r_data;
      @(posedge clk); #1;
      idle_inputs();
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grnt"}, bmu_ifu_grnt, 1'b0);
    check({tag, "_cmplt"}, bmu_ifu_trans_cmplt, 1'b0);
    check({tag, "_err"}, bmu_ifu_acc_err, 1'b0);
    check({tag, "_dvld"}, bmu_ifu_data_vld, 1'b0);
    check_w({tag, "_data"}, bmu_ifu_data, 32'd0);
    check({tag, "_req"}, bus_req, 1'b0);
    check_w({tag, "_addr"}, bus_addr, 32'd0);
    check({tag, "_write"}, bus_write, 1'b0);
    check({tag, "_deny"}, bus_deny, 1'b0);
  endtask

  vec_t vecs[9];
  vec_t plain;

  initial begin
    // addr, wr, deny, G, W, r_err, r_dvld, r_data, e_err, e_dvld, e_data, lat
    vecs[0] = '{32'h0000_1000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hDEAD_BEEF, 3};
    vecs[1] = '{32'h0000_2004, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 3};
    vecs[2] = '{32'h0000_2008, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 32'h5555_AAAA, 1'b1, 1'b0, 32'h0000_0000, 3};
    vecs[3] = '{32'h8000_0010, 1'b1, 1'b0, 2, 1, 1'b0, 1'b0, 32'h1111_2222, 1'b0, 1'b0, 32'h0000_0000, 6};
    vecs[4] = '{32'h0000_3000, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 3};
    vecs[5] = '{32'hFFFF_FFFC, 1'b1, 1'b1, 2, 0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 5};
    vecs[6] = '{32'h0000_4000, 1'b0, 1'b0, 4, 0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 32'hCAFE_F00D, 7};
    vecs[7] = '{32'h0000_5000, 1'b0, 1'b0, 0, 3, 1'b0, 1'b1, 32'h0BAD_C0DE, 1'b0, 1'b1, 32'h0BAD_C0DE, 6};
    vecs[8] = '{32'h0000_6000, 1'b0, 1'b0, 1, 2, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0001, 6};
    plain   = '{32'h0000_7000, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 32'h0F0F_1234, 1'b0, 1'b1, 32'h0F0F_1234, 3};

    // Reset state.
    idle_inputs();
    cpurst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    cpurst = 1'b0;

    // Table-driven transactions, issued back to back.
    for (int i = 0; i < 9; i++) do_txn(vecs[i]);

    // Timeout: granted immediately, responder silent; error at accept+6
    // (grant cycle + TIMEOUT_CYC + 1), then the late completion is dropped.
    begin
      int a;
      idle_inputs();
      ifu_bmu_req  = 1'b1;
      ifu_bmu_addr = 32'h0000_9000;
      @(negedge clk);
      check("to_accept", bmu_ifu_grnt, 1'b1);
      a = cyc;
      sb.push_back('{1'b1, 1'b0, 32'd0, a + 6});
      @(posedge clk); #1;
      ifu_bmu_req = 1'b0;
      tc_grnt     = 1'b1;
      @(negedge clk);
      check("to_bus_req", bus_req, 1'b1);
      @(posedge clk); #1;
      tc_grnt = 1'b0;
      // WAIT cycles a+2..a+5, response at a+6, FLUSH from a+6 on.
      repeat (4) @(posedge clk);
      #1;
      ifu_bmu_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        check("flush_no_grnt", bmu_ifu_grnt, 1'b0);
        check("flush_req_low", bus_req, 1'b0);
        @(posedge clk); #1;
      end
      ifu_bmu_req = 1'b0;
      tc_cmplt    = 1'b1;
      tc_dvld     = 1'b1;
      tc_data     = 32'h0000_1234;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("flush_discard", bmu_ifu_trans_cmplt, 1'b0);
      @(posedge clk); #1;
      do_txn(plain);
    end

    // Reset in WAIT, then a stray completion, then a normal request.
    begin
      idle_inputs();
      ifu_bmu_req   = 1'b1;
      ifu_bmu_addr  = 32'hA5A5_0040;
      ifu_bmu_write = 1'b1;
      @(negedge clk);
      check("rst_accept", bmu_ifu_grnt, 1'b1);
      @(posedge clk); #1;
      idle_inputs();
      tc_grnt = 1'b1;
      @(posedge clk); #1;
      tc_grnt = 1'b0;
      @(posedge clk); #1;
      cpurst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("midrst");
      @(posedge clk); #1;
      cpurst   = 1'b0;
      tc_cmplt = 1'b1;
      tc_dvld  = 1'b1;
      tc_data  = 32'h0000_0077;
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      check("stray_ignored", bmu_ifu_trans_cmplt, 1'b0);
      @(posedge clk); #1;
      do_txn(plain);
    end

    // Let the last response land; a missing one is a failure.
    for (int k = 0; k < 20; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    @(negedge clk);
    check_w("drain", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
